// File: rtl/meteo_rst_pkg.sv
// Shared types for the meteorolite reset sequencer: FSM states and RST_CAUSE bit positions.
package meteo_rst_pkg;

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    SYS_HOLD = 2'd1,
    RUN      = 2'd2
  } rst_state_e;

  localparam int unsigned CAUSE_BTN  = 0;
  localparam int unsigned CAUSE_DBG  = 1;
  localparam int unsigned CAUSE_CORE = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/meteo_rst_ctrl_if.sv
// Core-facing reset bundle: reset requests from the core, stretched resets back to it.
interface meteo_rst_ctrl_if;
  logic SYSRESETREQ;
  logic LOCKUP;
  logic PORESETn;
  logic HRESETn;

  modport master (
    input  SYSRESETREQ,
    input  LOCKUP,
    output PORESETn,
    output HRESETn
  );

  modport slave (
    output SYSRESETREQ,
    output LOCKUP,
    input  PORESETn,
    input  HRESETn
  );
endinterface

// File: rtl/meteo_rst_ctrl_debounce.sv
// Synchroniser plus stable-count filter: output flips only after DEBOUNCE_CYCLES
// consecutive synced samples disagree with it.
module meteo_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign dout   = db_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d  = '0;
    db_d   = db_q;
    // Any agreeing sample restarts the stability count.
    if (synced != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
      db_q   <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

endmodule

// File: rtl/meteo_rst_ctrl.sv
// Reset sequencer for the meteorolite core: stretched PORESETn/HRESETn and sticky cause.
// Build option: define METEO_LOCKUP_RST_EN to let LOCKUP trigger system reset.
module meteo_rst_ctrl
  import meteo_rst_pkg::*;
#(
  parameter int unsigned POR_CYCLES      = 256,
  parameter int unsigned RST_CYCLES      = 64,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                    OSCCLK,
  input  logic                    CB_nPOR,
  input  logic                    CB_nRST,
  input  logic                    CS_nSRST,
  meteo_rst_ctrl_if.master        core,
  output logic                    FLAG_NPOR,
  output logic                    FLAG_RESET_N,
  output logic [2:0]              RST_CAUSE
);

  localparam int unsigned      CNT_MAX  = max_u(POR_CYCLES, RST_CYCLES);
  localparam int unsigned      CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] por_sync_q, por_sync_d;
  logic [SYNC_STAGES-1:0] srst_sync_q, srst_sync_d;
  rst_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   poresetn_q, poresetn_d;
  logic                   hresetn_q, hresetn_d;
  logic [2:0]             cause_q, cause_d;

  logic       por_rel;
  logic       srst_sync;
  logic       btn_db;
  logic       core_req;
  logic       sys_src;
  logic [2:0] src_vec;

  meteo_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk  (OSCCLK),
    .rst_n(CB_nPOR),
    .din  (CB_nRST),
    .dout (btn_db)
  );

  assign por_rel   = por_sync_q[SYNC_STAGES-1];
  assign srst_sync = srst_sync_q[SYNC_STAGES-1];

`ifdef METEO_LOCKUP_RST_EN
  assign core_req = core.SYSRESETREQ | core.LOCKUP;
`else
  logic unused_lockup;
  assign unused_lockup = core.LOCKUP;
  assign core_req      = core.SYSRESETREQ;
`endif

  always_comb begin
    src_vec             = '0;
    src_vec[CAUSE_BTN]  = ~btn_db;
    src_vec[CAUSE_DBG]  = ~srst_sync;
    src_vec[CAUSE_CORE] = core_req;
  end

  assign sys_src = |src_vec;

  always_comb begin
    por_sync_d  = {por_sync_q[SYNC_STAGES-2:0], 1'b1};
    srst_sync_d = {srst_sync_q[SYNC_STAGES-2:0], CS_nSRST};
    state_d     = state_q;
    cnt_d       = cnt_q;
    poresetn_d  = poresetn_q;
    hresetn_d   = hresetn_q;
    cause_d     = cause_q;

    unique case (state_q)
      POR_HOLD: begin
        if (por_rel) begin
          if (cnt_q == POR_LAST) begin
            poresetn_d = 1'b1;
            cnt_d      = RST_LOAD;
            state_d    = SYS_HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SYS_HOLD: begin
        // Down-count only while every source is quiet; any source reloads.
        if (sys_src) begin
          cnt_d = RST_LOAD;
        end else if (cnt_q == CNT_ONE) begin
          hresetn_d = 1'b1;
          state_d   = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (sys_src) begin
          hresetn_d = 1'b0;
          cnt_d     = RST_LOAD;
          cause_d   = src_vec;
          state_d   = SYS_HOLD;
        end
      end
      default: begin
        state_d    = POR_HOLD;
        cnt_d      = '0;
        poresetn_d = 1'b0;
        hresetn_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge OSCCLK or negedge CB_nPOR) begin
    if (!CB_nPOR) begin
      por_sync_q  <= '0;
      srst_sync_q <= '1;
      state_q     <= POR_HOLD;
      cnt_q       <= '0;
      poresetn_q  <= 1'b0;
      hresetn_q   <= 1'b0;
      cause_q     <= '0;
    end else begin
      por_sync_q  <= por_sync_d;
      srst_sync_q <= srst_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      poresetn_q  <= poresetn_d;
      hresetn_q   <= hresetn_d;
      cause_q     <= cause_d;
    end
  end

  assign core.PORESETn = poresetn_q;
  assign core.HRESETn  = hresetn_q;
  assign FLAG_NPOR     = poresetn_q;
  assign FLAG_RESET_N  = hresetn_q;
  assign RST_CAUSE     = cause_q;

endmodule

// File: tb/tb_meteo_rst_ctrl.sv
// Bench for meteo_rst_ctrl: directed scenarios plus a randomized run against a reference model.
module tb_meteo_rst_ctrl;

  localparam int unsigned POR  = 8;
  localparam int unsigned RST  = 4;
  localparam int unsigned DEB  = 16;
  localparam int unsigned SYNC = 2;

  logic       OSCCLK = 1'b0;
  logic       CB_nPOR, CB_nRST, CS_nSRST;
  logic       FLAG_NPOR, FLAG_RESET_N;
  logic [2:0] RST_CAUSE;

  meteo_rst_ctrl_if core_if();

  meteo_rst_ctrl #(
    .POR_CYCLES     (POR),
    .RST_CYCLES     (RST),
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .OSCCLK      (OSCCLK),
    .CB_nPOR     (CB_nPOR),
    .CB_nRST     (CB_nRST),
    .CS_nSRST    (CS_nSRST),
    .core        (core_if),
    .FLAG_NPOR   (FLAG_NPOR),
    .FLAG_RESET_N(FLAG_RESET_N),
    .RST_CAUSE   (RST_CAUSE)
  );

  always #5 OSCCLK = ~OSCCLK;

  int checks = 0;
  int fails  = 0;

  // Reference model: edges since release, raw sample histories, and the
  // externally visible consequences (hold phase, quiet edges, outputs).
  int unsigned n;
  bit          b_hist[$];
  bit          s_hist[$];
  bit          bsync_hist[$];
  bit          m_db, m_por, m_h;
  int          phase;
  int          quiet;
  logic [2:0]  m_cause;

  function automatic void model_reset();
    n = 0;
    b_hist.delete();
    s_hist.delete();
    bsync_hist.delete();
    m_db    = 1'b1;
    m_por   = 1'b0;
    m_h     = 1'b0;
    phase   = 0;
    quiet   = 0;
    m_cause = 3'b000;
  endfunction

  function automatic void model_edge();
    bit sb, ss, creq, src, all_diff;
    if (!CB_nPOR) begin
      model_reset();
      return;
    end
    n++;
    b_hist.push_back(CB_nRST);
    s_hist.push_back(CS_nSRST);
    sb = (n > SYNC) ? b_hist[n-SYNC-1] : 1'b1;
    ss = (n > SYNC) ? s_hist[n-SYNC-1] : 1'b1;
`ifdef METEO_LOCKUP_RST_EN
    creq = core_if.SYSRESETREQ | core_if.LOCKUP;
`else
    creq = core_if.SYSRESETREQ;
`endif
    src = !m_db || !ss || creq;
    if (phase == 0) begin
      if (n == SYNC + POR) begin
        m_por = 1'b1;
        phase = 1;
        quiet = 0;
      end
    end else if (phase == 1) begin
      quiet = src ? 0 : quiet + 1;
      if (quiet == RST) begin
        m_h   = 1'b1;
        phase = 2;
      end
    end else if (src) begin
      m_h     = 1'b0;
      phase   = 1;
      quiet   = 0;
      m_cause = {creq, !ss, !m_db};
    end
    bsync_hist.push_back(sb);
    if (bsync_hist.size() >= DEB) begin
      all_diff = 1'b1;
      for (int unsigned i = bsync_hist.size() - DEB; i < bsync_hist.size(); i++)
        if (bsync_hist[i] == m_db) all_diff = 1'b0;
      if (all_diff) m_db = !m_db;
    end
  endfunction

  function automatic logic [6:0] obs();
    return {core_if.PORESETn, core_if.HRESETn, FLAG_NPOR, FLAG_RESET_N, RST_CAUSE};
  endfunction

  function automatic logic [6:0] expv();
    return {m_por, m_h, m_por, m_h, m_cause};
  endfunction

  task automatic step();
    @(posedge OSCCLK);
    model_edge();
    @(negedge OSCCLK);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== 7'b0) begin
        fails++;
        $display("FAIL reset_state: got %b expected %b", obs(), 7'b0);
      end
    end
  endtask

  task automatic test_por_release();
    CB_nPOR = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL por_seq edge %0d: got %b expected %b", e, obs(), expv());
      end
      if (e == 9 || e == 10) begin
        checks++;
        if (core_if.PORESETn !== (e == 10)) begin
          fails++;
          $display("FAIL por_edge %0d: got %b expected %b", e, core_if.PORESETn, (e == 10));
        end
      end
      if (e == 13 || e == 14) begin
        checks++;
        if (core_if.HRESETn !== (e == 14)) begin
          fails++;
          $display("FAIL hrst_edge %0d: got %b expected %b", e, core_if.HRESETn, (e == 14));
        end
      end
    end
    checks++;
    if (RST_CAUSE !== 3'b000) begin
      fails++;
      $display("FAIL por_cause: got %b expected 000", RST_CAUSE);
    end
  endtask

  task automatic test_sysresetreq();
    int unsigned idle;
    idle = $urandom_range(1, 5);
    for (int unsigned i = 0; i < idle; i++) step();
    core_if.SYSRESETREQ = 1'b1;
    step();
    core_if.SYSRESETREQ = 1'b0;
    checks++;
    if (core_if.HRESETn !== 1'b0) begin
      fails++;
      $display("FAIL req_fall: got %b expected 0", core_if.HRESETn);
    end
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL req_seq edge %0d: got %b expected %b", e, obs(), expv());
      end
      if (e == 3 || e == 4) begin
        checks++;
        if (core_if.HRESETn !== (e == 4)) begin
          fails++;
          $display("FAIL req_rise edge %0d: got %b expected %b", e, core_if.HRESETn, (e == 4));
        end
      end
    end
    checks++;
    if ({core_if.PORESETn, RST_CAUSE} !== 4'b1100) begin
      fails++;
      $display("FAIL req_cause: got %b expected 1100", {core_if.PORESETn, RST_CAUSE});
    end
  endtask

  task automatic test_button_bounce();
    for (int c = 0; c < 40; c++) begin
      CB_nRST = ((c / 5) % 2) ? 1'b1 : 1'b0;
      step();
      checks++;
      if (core_if.HRESETn !== 1'b1 || obs() !== expv()) begin
        fails++;
        $display("FAIL btn_bounce cyc %0d: got %b expected %b", c, obs(), expv());
      end
    end
    CB_nRST = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL btn_low cyc %0d: got %b expected %b", c, obs(), expv());
      end
      if (c == 17 || c == 18) begin
        checks++;
        if (core_if.HRESETn !== (c == 17)) begin
          fails++;
          $display("FAIL btn_fall cyc %0d: got %b expected %b", c, core_if.HRESETn, (c == 17));
        end
      end
    end
    CB_nRST = 1'b1;
    for (int c = 0; c < 26; c++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL btn_rel cyc %0d: got %b expected %b", c, obs(), expv());
      end
      if (c == 20 || c == 21) begin
        checks++;
        if (core_if.HRESETn !== (c == 21)) begin
          fails++;
          $display("FAIL btn_rise cyc %0d: got %b expected %b", c, core_if.HRESETn, (c == 21));
        end
      end
    end
    checks++;
    if (RST_CAUSE !== 3'b001) begin
      fails++;
      $display("FAIL btn_cause: got %b expected 001", RST_CAUSE);
    end
  endtask

  task automatic test_dbg_and_req();
    CS_nSRST = 1'b0;
    step();
    step();
    core_if.SYSRESETREQ = 1'b1;
    step();
    core_if.SYSRESETREQ = 1'b0;
    checks++;
    if ({core_if.HRESETn, RST_CAUSE} !== 4'b0110) begin
      fails++;
      $display("FAIL dbg_cause: got %b expected 0110", {core_if.HRESETn, RST_CAUSE});
    end
    for (int c = 0; c < 7; c++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL dbg_hold cyc %0d: got %b expected %b", c, obs(), expv());
      end
    end
    CS_nSRST = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL dbg_rel cyc %0d: got %b expected %b", c, obs(), expv());
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (core_if.HRESETn !== (c == 5)) begin
          fails++;
          $display("FAIL dbg_rise cyc %0d: got %b expected %b", c, core_if.HRESETn, (c == 5));
        end
      end
    end
  endtask

  task automatic test_lockup();
    logic       exp_h_first;
    logic [2:0] exp_cause;
`ifdef METEO_LOCKUP_RST_EN
    exp_h_first = 1'b0;
    exp_cause   = 3'b100;
`else
    exp_h_first = 1'b1;
    exp_cause   = 3'b110;
`endif
    core_if.LOCKUP = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL lockup_on cyc %0d: got %b expected %b", c, obs(), expv());
      end
      if (c == 0) begin
        checks++;
        if (core_if.HRESETn !== exp_h_first) begin
          fails++;
          $display("FAIL lockup_h: got %b expected %b", core_if.HRESETn, exp_h_first);
        end
      end
    end
    core_if.LOCKUP = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL lockup_off cyc %0d: got %b expected %b", c, obs(), expv());
      end
    end
    checks++;
    if ({core_if.HRESETn, RST_CAUSE} !== {1'b1, exp_cause}) begin
      fails++;
      $display("FAIL lockup_cause: got %b expected %b", {core_if.HRESETn, RST_CAUSE}, {1'b1, exp_cause});
    end
  endtask

  task automatic test_por_mid_hold();
    core_if.SYSRESETREQ = 1'b1;
    step();
    core_if.SYSRESETREQ = 1'b0;
    step();
    CB_nPOR = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== 7'b0) begin
      fails++;
      $display("FAIL por_async: got %b expected %b", obs(), 7'b0);
    end
    for (int c = 0; c < 3; c++) step();
    CB_nPOR = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL repor_seq edge %0d: got %b expected %b", e, obs(), expv());
      end
      if (e == 9 || e == 10) begin
        checks++;
        if (core_if.PORESETn !== (e == 10)) begin
          fails++;
          $display("FAIL repor_edge %0d: got %b expected %b", e, core_if.PORESETn, (e == 10));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) CB_nRST = ~CB_nRST;
      if ($urandom_range(0, 39) == 0) CS_nSRST = ~CS_nSRST;
      core_if.SYSRESETREQ = ($urandom_range(0, 29) == 0);
      core_if.LOCKUP      = ($urandom_range(0, 29) == 0);
      if (CB_nPOR && $urandom_range(0, 499) == 0) begin
        CB_nPOR = 1'b0;
        model_reset();
      end else if (!CB_nPOR && $urandom_range(0, 2) == 0) begin
        CB_nPOR = 1'b1;
      end
      step();
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL random cyc %0d: got %b expected %b", c, obs(), expv());
      end
    end
  endtask

  initial begin
    CB_nPOR             = 1'b0;
    CB_nRST             = 1'b1;
    CS_nSRST            = 1'b1;
    core_if.SYSRESETREQ = 1'b0;
    core_if.LOCKUP      = 1'b0;
    model_reset();
    @(negedge OSCCLK);
    test_reset();
    test_por_release();
    test_sysresetreq();
    test_button_bounce();
    test_dbg_and_req();
    test_lockup();
    test_por_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
